register_file_2w: RTL and testbench



---
 rtl/register_file_2w.sv | 47 ++++
 tb/tb_register_file_2w.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_2w.sv
// register_file_2w: dual-write, dual-read register file with write-to-read bypass and optional hardwired zero register
module register_file_2w #(
    parameter int N        = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          WE3,
    input  logic [AW-1:0] A3,
    input  logic [N-1:0]  WD3,
    input  logic          WE4,
    input  logic [AW-1:0] A4,
    input  logic [N-1:0]  WD4,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [N-1:0]  RD1,
    output logic [N-1:0]  RD2
);
    logic [N-1:0] mem [0:(1<<AW)-1];
    logic         w3_ok, w4_ok, byp;
    // qualified write enables: writes to r0 are dropped when it is hardwired
    always_comb begin
        w3_ok = WE3 && !(ZERO_REG != 0 && A3 == '0);
        w4_ok = WE4 && !(ZERO_REG != 0 && A4 == '0);
        byp   = BYPASS != 0 && !reset;
    end
    // array update; port 4 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else begin
            if (w3_ok) mem[A3] <= WD3;
            if (w4_ok) mem[A4] <= WD4;
        end
    end
    // read ports: zero register, then port 4 bypass, then port 3 bypass, then array
    always_comb begin
        RD1 = (ZERO_REG != 0 && A1 == '0) ? '0 :
              (byp && WE4 && A4 == A1)   ? WD4 :
              (byp && WE3 && A3 == A1)   ? WD3 : mem[A1];
        RD2 = (ZERO_REG != 0 && A2 == '0) ? '0 :
              (byp && WE4 && A4 == A2)   ? WD4 :
              (byp && WE3 && A3 == A2)   ? WD3 : mem[A2];
    end
endmodule

// File: tb/tb_register_file_2w.sv
// tb_register_file_2w: scoreboard bench covering default, no-bypass/no-zero and narrow configurations
module tb_register_file_2w;
    logic        clk = 0;
    logic        reset;
    logic        we3, we4;
    logic [4:0]  a3, a4, a1, a2;
    logic [31:0] wd3, wd4;
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        s_we3, s_we4;
    logic [2:0]  s_a3, s_a4, s_a1, s_a2;
    logic [7:0]  s_wd3, s_wd4, s_rd1, s_rd2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;
    chk_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_2w u0 (
        .clk(clk), .reset(reset), .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
        .A1(a1), .A2(a2), .RD1(rd1_0), .RD2(rd2_0)
    );
    register_file_2w #(.BYPASS(0), .ZERO_REG(0)) u1 (
        .clk(clk), .reset(reset), .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
        .A1(a1), .A2(a2), .RD1(rd1_1), .RD2(rd2_1)
    );
    register_file_2w #(.N(8), .AW(3)) u2 (
        .clk(clk), .reset(reset), .WE3(s_we3), .A3(s_a3), .WD3(s_wd3), .WE4(s_we4), .A4(s_a4), .WD4(s_wd4),
        .A1(s_a1), .A2(s_a2), .RD1(s_rd1), .RD2(s_rd2)
    );

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return rd1_0;
            1: return rd2_0;
            2: return rd1_1;
            3: return rd2_1;
            4: return {24'b0, s_rd1};
            default: return {24'b0, s_rd2};
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic cyc(input logic w3, input logic [4:0] ad3, input logic [31:0] d3,
                       input logic w4, input logic [4:0] ad4, input logic [31:0] d4,
                       input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        we3 = w3; a3 = ad3; wd3 = d3; we4 = w4; a4 = ad4; wd4 = d4; a1 = r1; a2 = r2;
    endtask

    task automatic scyc(input logic w3, input logic [2:0] ad3, input logic [7:0] d3,
                        input logic w4, input logic [2:0] ad4, input logic [7:0] d4,
                        input logic [2:0] r1, input logic [2:0] r2);
        @(posedge clk);
        #1;
        s_we3 = w3; s_a3 = ad3; s_wd3 = d3; s_we4 = w4; s_a4 = ad4; s_wd4 = d4; s_a1 = r1; s_a2 = r2;
    endtask

    // monitor: outputs are sampled on the falling edge, away from the write edge
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = actual(c.sel);
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s (sel %0d): got %h expected %h", c.name, c.sel, act, c.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] sm [8];
        reset = 1;
        {we3, we4, a3, a4, a1, a2, wd3, wd4} = '0;
        {s_we3, s_we4, s_a3, s_a4, s_a1, s_a2, s_wd3, s_wd4} = '0;
        cyc(0, 0, 0, 0, 0, 0, 5, 31);
        reset = 0;
        expect_val("reset_u0_rd1", 0, 0);
        expect_val("reset_u0_rd2", 1, 0);
        expect_val("reset_u1_rd1", 2, 0);
        expect_val("reset_u1_rd2", 3, 0);
        expect_val("reset_u2_rd1", 4, 0);
        cyc(1, 1, 32'hABD2ABD1, 0, 0, 0, 1, 2);
        expect_val("pre_rst_byp_u0", 0, 32'hABD2ABD1);
        expect_val("pre_rst_nobyp_u1", 2, 0);
        cyc(1, 2, 32'h1234, 0, 0, 0, 1, 2);
        reset = 1;
        expect_val("rst_arr_u0_rd1", 0, 32'hABD2ABD1);
        expect_val("rst_nobyp_u0_rd2", 1, 0);
        expect_val("rst_arr_u1_rd1", 2, 32'hABD2ABD1);
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        reset = 0;
        expect_val("rst_clr_u0_rd1", 0, 0);
        expect_val("rst_clr_u0_rd2", 1, 0);
        expect_val("rst_clr_u1_rd1", 2, 0);
        expect_val("rst_clr_u1_rd2", 3, 0);
        cyc(1, 1, 32'hABF2ABD1, 0, 0, 0, 0, 0);
        cyc(1, 2, 32'hABF2ABD2, 0, 0, 0, 0, 0);
        cyc(1, 3, 32'hABF2ABD3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2, 3);
        expect_val("basic_u0_rd1", 0, 32'hABF2ABD2);
        expect_val("basic_u0_rd2", 1, 32'hABF2ABD3);
        expect_val("basic_u1_rd1", 2, 32'hABF2ABD2);
        expect_val("basic_u1_rd2", 3, 32'hABF2ABD3);
        cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        expect_val("zero_during_u0", 0, 0);
        expect_val("zero_during_u1", 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val("zero_after_u0", 0, 0);
        expect_val("zero_after_u1", 2, 32'hFFFFFFFF);
        cyc(1, 5, 32'h55, 1, 6, 32'h66, 0, 0);
        cyc(1, 7, 32'h77, 1, 7, 32'h88, 5, 6);
        expect_val("dual_r5_u0", 0, 32'h55);
        expect_val("dual_r6_u0", 1, 32'h66);
        expect_val("dual_r5_u1", 2, 32'h55);
        expect_val("dual_r6_u1", 3, 32'h66);
        cyc(0, 0, 0, 0, 0, 0, 7, 7);
        expect_val("collide_u0_rd1", 0, 32'h88);
        expect_val("collide_u0_rd2", 1, 32'h88);
        expect_val("collide_u1_rd1", 2, 32'h88);
        expect_val("collide_u1_rd2", 3, 32'h88);
        cyc(1, 9, 32'h11, 0, 0, 0, 9, 9);
        expect_val("byp_w11_u0", 0, 32'h11);
        expect_val("byp_w11_u1", 2, 0);
        cyc(1, 9, 32'h22, 0, 0, 0, 9, 9);
        expect_val("byp_p3_u0", 0, 32'h22);
        expect_val("byp_p3_u1", 2, 32'h11);
        cyc(1, 9, 32'h11, 0, 0, 0, 9, 9);
        expect_val("byp_rewrite_u0", 0, 32'h11);
        expect_val("byp_rewrite_u1", 2, 32'h22);
        cyc(1, 9, 32'h22, 1, 9, 32'h33, 9, 9);
        expect_val("byp_p4_u0_rd1", 0, 32'h33);
        expect_val("byp_p4_u0_rd2", 1, 32'h33);
        expect_val("byp_p4_u1_rd1", 2, 32'h11);
        cyc(0, 0, 0, 0, 0, 0, 9, 9);
        expect_val("byp_after_u0", 0, 32'h33);
        expect_val("byp_after_u1_rd1", 2, 32'h33);
        expect_val("byp_after_u1_rd2", 3, 32'h33);
        cyc(0, 0, 0, 1, 0, 32'hABC, 0, 0);
        expect_val("zero_byp_p4_u0", 0, 0);
        expect_val("zero_byp_p4_u1", 2, 32'hFFFFFFFF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        expect_val("zero_p4_after_u0", 0, 0);
        expect_val("zero_p4_after_u1", 2, 32'hABC);
        scyc(1, 7, 8'hA5, 1, 0, 8'h5A, 7, 0);
        expect_val("small_byp_r7", 4, 8'hA5);
        expect_val("small_byp_r0", 5, 0);
        scyc(0, 0, 0, 0, 0, 0, 7, 0);
        expect_val("small_r7", 4, 8'hA5);
        expect_val("small_r0", 5, 0);
        sm[0] = 8'h00;
        sm[7] = 8'hA5;
        for (int i = 1; i < 7; i++) begin
            sm[i] = 8'(8'h11 * i);
            scyc(1, 3'(i), sm[i], 0, 0, 0, 3'(i), 0);
            expect_val("small_wr_byp", 4, {24'b0, sm[i]});
        end
        for (int i = 0; i < 8; i++) begin
            scyc(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
            expect_val("small_sweep_rd1", 4, {24'b0, sm[i]});
            expect_val("small_sweep_rd2", 5, {24'b0, sm[7 - i]});
        end
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
